// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard and stall controller for a classic 5-stage pipeline.
//
// It drives the write-enable and flush/bubble controls of PC, IF/ID, ID/EX,
// EX/MEM and MEM/WB.
//
// Three hazard conditions are handled, highest priority first:
//   - memory stall: a multi-cycle data access freezes the whole pipe;
//   - taken branch: the branch resolves in MEM and two bubble cycles follow;
//   - load-use: one bubble is inserted behind a load.
//
// Optional feature: define HAZ_PERF_CNT_EN to add saturating performance
// counters (loaduse_cnt, branch_cnt, memwait_cnt).
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  branch_taken,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_write,
  output logic                  pc_sel_branch,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_write,
  output logic                  idex_bubble,
  output logic                  exmem_write,
  output logic                  exmem_flush,
  output logic                  memwb_bubble,
  output logic                  mem_err
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      loaduse_cnt,
  output logic [CNT_W-1:0]      branch_cnt,
  output logic [CNT_W-1:0]      memwait_cnt
`endif
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_MEM_WAIT,
    S_FLUSH
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          mem_err_q, mem_err_d;
  // A branch's second flush cycle that was postponed by a memory stall.
  logic          flush_pend_q, flush_pend_d;

  logic load_use;
  logic mem_stall;
  logic mem_timeout;

  // Hazard detection; register x0 never creates a load-use hazard.
  always_comb begin
    load_use = idex_mem_read && (idex_rd != '0) &&
               ((idex_rd == id_rs1) || (idex_rd == id_rs2));
    if (state_q == S_MEM_WAIT) begin
      mem_stall   = !dmem_ready && (wait_cnt_q != WAIT_LAST);
      mem_timeout = !dmem_ready && (wait_cnt_q == WAIT_LAST);
    end else begin
      mem_stall   = dmem_req && !dmem_ready;
      mem_timeout = 1'b0;
    end
  end

  // Next-state and control outputs, resolved in priority order.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_err_d     = mem_err_q;
    flush_pend_d  = flush_pend_q;
    pc_write      = 1'b1;
    pc_sel_branch = 1'b0;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_write    = 1'b1;
    idex_bubble   = 1'b0;
    exmem_write   = 1'b1;
    exmem_flush   = 1'b0;
    memwb_bubble  = 1'b0;
    mem_err       = mem_err_q;

    if (mem_stall) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
      state_d      = S_MEM_WAIT;
      wait_cnt_d   = (state_q == S_MEM_WAIT) ? wait_cnt_q + 1'b1 : CW'(1);
      if (state_q == S_FLUSH) begin
        flush_pend_d = 1'b1;
      end
    end else if (mem_timeout) begin
      memwb_bubble = 1'b1;
      mem_err_d    = 1'b1;
      wait_cnt_d   = '0;
      flush_pend_d = 1'b0;
      state_d      = flush_pend_q ? S_FLUSH : S_RUN;
    end else begin
      wait_cnt_d   = '0;
      flush_pend_d = 1'b0;
      state_d      = S_RUN;
      if (state_q == S_FLUSH) begin
        ifid_flush = 1'b1;
      end
      if ((state_q == S_MEM_WAIT) && flush_pend_q) begin
        state_d = S_FLUSH;
      end
      if (branch_taken) begin
        pc_sel_branch = 1'b1;
        pc_write      = 1'b1;
        ifid_flush    = 1'b1;
        idex_bubble   = 1'b1;
        exmem_flush   = 1'b1;
        state_d       = S_FLUSH;
      end else if (load_use) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end

    if (reset) begin
      pc_write      = 1'b1;
      pc_sel_branch = 1'b0;
      ifid_write    = 1'b1;
      ifid_flush    = 1'b0;
      idex_write    = 1'b1;
      idex_bubble   = 1'b0;
      exmem_write   = 1'b1;
      exmem_flush   = 1'b0;
      memwb_bubble  = 1'b0;
      mem_err       = 1'b0;
    end
  end

  // State, wait counter and sticky error register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_RUN;
      wait_cnt_q   <= '0;
      mem_err_q    <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_err_q    <= mem_err_d;
      flush_pend_q <= flush_pend_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic lu_act;
  logic br_act;
  logic mw_act;

  // Which priority case won this cycle.
  always_comb begin
    mw_act = mem_stall;
    br_act = !mem_stall && !mem_timeout && branch_taken;
    lu_act = !mem_stall && !mem_timeout && !branch_taken && load_use;
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      loaduse_cnt <= '0;
      branch_cnt  <= '0;
      memwait_cnt <= '0;
    end else begin
      if (lu_act && (loaduse_cnt != '1)) begin
        loaduse_cnt <= loaduse_cnt + 1'b1;
      end
      if (br_act && (branch_cnt != '1)) begin
        branch_cnt <= branch_cnt + 1'b1;
      end
      if (mw_act && (memwait_cnt != '1)) begin
        memwait_cnt <= memwait_cnt + 1'b1;
      end
    end
  end
`endif

endmodule
